// File: rtl/gng_axis_out.sv
// Output stage for the noise generator: gain scaling, round/saturate, FWFT FIFO and AXI-Stream.
// Define GNG_AXIS_TLAST_EN to enable the frame counter that drives m_axis_tlast.
`timescale 1ns/1ps

module gng_axis_out #(
  parameter int unsigned FIFO_AW   = 4,
  parameter int unsigned FRAME_LEN = 256
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        valid_in,
  input  logic [15:0] data_in,
  input  logic [15:0] gain,
  input  logic        clr,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tlast,
  output logic [15:0] drop_cnt,
  output logic        sat_flag
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] PtrOne = {{FIFO_AW{1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Stage 1: signed product of the sample and the zero-extended gain
  // ---------------------------------------------------------------------------
  logic               v1_q;
  logic               v2_q;
  logic signed [32:0] din_s;
  logic signed [32:0] gain_s;
  logic signed [32:0] p1_q;

  assign din_s  = {{17{data_in[15]}}, data_in};
  assign gain_s = {17'd0, gain};

  // ---------------------------------------------------------------------------
  // Stage 2: round half toward +inf, shift back to s<16,11>, saturate
  // ---------------------------------------------------------------------------
  logic signed [32:0] rnd;
  logic signed [32:0] shf;
  logic               clip_hi;
  logic               clip_lo;
  logic        [15:0] r2_d;
  logic        [15:0] r2_q;
  logic               sat_set;

  assign rnd     = p1_q + 33'sd2048;
  assign shf     = rnd >>> 12;
  assign clip_hi = shf > 33'sd32767;
  assign clip_lo = shf < -33'sd32768;
  assign sat_set = v1_q && (clip_hi || clip_lo);

  always_comb begin
    r2_d = shf[15:0];
    if (clip_hi) begin
      r2_d = 16'h7fff;
    end else if (clip_lo) begin
      r2_d = 16'h8000;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= valid_in;
      v2_q <= v1_q;
    end
  end

  // Data path registers are intentionally not reset; only the valids qualify them.
  always_ff @(posedge clk) begin
    p1_q <= din_s * gain_s;
    r2_q <= r2_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sat_flag <= 1'b0;
    end else if (clr) begin
      sat_flag <= 1'b0;
    end else if (sat_set) begin
      sat_flag <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // First-word-fall-through FIFO
  // ---------------------------------------------------------------------------
  logic [FIFO_AW:0] wr_ptr_q;
  logic [FIFO_AW:0] rd_ptr_q;
  logic [15:0]      mem [Depth];
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  assign empty = wr_ptr_q == rd_ptr_q;
  assign full  = (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]) &&
                 (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]);
  assign pop   = !empty && m_axis_tready;
  // A pop frees the slot in the same cycle, so a write into a full FIFO still lands.
  assign push  = v2_q && (!full || pop);
  assign drop  = v2_q && full && !pop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[FIFO_AW-1:0]] <= r2_q;
    end
  end

  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = mem[rd_ptr_q[FIFO_AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_cnt <= '0;
    end else if (clr) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 16'hffff)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame marker
  // ---------------------------------------------------------------------------
`ifdef GNG_AXIS_TLAST_EN
  localparam logic [15:0] FrameLast = 16'(FRAME_LEN - 1);

  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt_q <= '0;
    end else if (pop) begin
      frame_cnt_q <= (frame_cnt_q == FrameLast) ? 16'd0 : frame_cnt_q + 16'd1;
    end
  end

  // Counter only moves on a handshake, so tlast is stable during backpressure.
  assign m_axis_tlast = !empty && (frame_cnt_q == FrameLast);
`else
  assign m_axis_tlast = 1'b0;
`endif

endmodule
